mp_add_seq: RTL and testbench



---
 rtl/mp_add_pkg.sv | 16 +
 rtl/mp_add_seq_word_add.sv | 28 ++
 rtl/mp_add_seq.sv | 126 ++++++++++++
 tb/tb_mp_add_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared types and defaults for the multi-precision add sequencer.
//   state_t     - sequencer states (IDLE, RUN, DONE)
//   DEF_WIDTH   - default word width fed to the word adder
//   DEF_WORDS   - default number of words per operand
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_WORDS = 4;

endpackage

// File: rtl/mp_add_seq_word_add.sv
// word_add: combinational WIDTH-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b  in  WIDTH  addend words
//   cin   in  1      carry into bit 0
//   sum   out WIDTH  sum word
//   cout  out 1      carry out of the top bit
module word_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: WORDS x WIDTH-bit adder that reuses one WIDTH-bit word adder,
// processing one word per clock from LSW to MSW with a registered carry chain.
// Optional feature: define MP_ADD_SUB_EN to add the 'sub' input (s = a - b).
// Ports:
//   clk    in  1            rising-edge clock
//   rst    in  1            synchronous active-high reset
//   start  in  1            request pulse, honoured only in IDLE
//   a, b   in  WIDTH*WORDS  operands, captured on the accepted start
//   ci     in  1            carry into word 0, captured on the accepted start
//   sub    in  1            (MP_ADD_SUB_EN only) subtract select, captured with start
//   busy   out 1            high in RUN and DONE
//   done   out 1            one-cycle pulse when s/co are valid
//   s      out WIDTH*WORDS  registered sum
//   co     out 1            registered carry out of the MSW (1 = no borrow when subtracting)
//
// state | meaning
// IDLE  | waiting for start; s/co hold last result
// RUN   | adding word k, one word per cycle
// DONE  | result valid, done pulse for one cycle
module mp_add_seq import mp_add_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   ci,
`ifdef MP_ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] s,
  output logic                   co
);

  localparam int N  = WIDTH * WORDS;
  localparam int KW = $clog2(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t         state, state_nx;
  logic [KW-1:0]  k;
  logic           cr;
  logic [N-1:0]   a_r, b_r;
  logic [N-1:0]   b_load;
  logic           cr_load;
  logic [WIDTH-1:0] a_w, b_w, w;
  logic           c;

  // Subtraction is folded into capture: store ~b and seed the carry with 1.
`ifdef MP_ADD_SUB_EN
  assign b_load  = sub ? ~b : b;
  assign cr_load = sub ? 1'b1 : ci;
`else
  assign b_load  = b;
  assign cr_load = ci;
`endif

  assign a_w = a_r[int'(k) * WIDTH +: WIDTH];
  assign b_w = b_r[int'(k) * WIDTH +: WIDTH];

  word_add #(.WIDTH(WIDTH)) u_word_add (
    .a    (a_w),
    .b    (b_w),
    .cin  (cr),
    .sum  (w),
    .cout (c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (k == K_LAST) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k   <= '0;
      cr  <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      s   <= '0;
      co  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b_load;
            cr  <= cr_load;
            k   <= '0;
          end
        end
        RUN: begin
          s[int'(k) * WIDTH +: WIDTH] <= w;
          cr <= c;
          // k holds at the last word so it never leaves 0..WORDS-1.
          if (k == K_LAST) co <= c;
          else             k  <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
module tb_mp_add_seq;

  localparam int WIDTH = 32;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a, b;
  logic         ci;
  logic         sub;
  logic         busy, done, co;
  logic [N-1:0] s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
`ifdef MP_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
  );

  // Reference: full-width arithmetic, carry out is bit N.
  function automatic logic [N:0] ref_calc(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic cin, input logic sb);
    if (sb) return {1'b0, x} + {1'b0, ~y} + (N+1)'(1);
    else    return {1'b0, x} + {1'b0, y} + (N+1)'(cin);
  endfunction

  function automatic logic [N-1:0] rand_wide();
    logic [N-1:0] r;
    for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Issues one operation and waits (bounded) for done; lat counts negedges
  // from the accepting edge up to the one where done is seen.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic cin,
                        input logic sb, output int lat, output int busy_cnt);
    @(negedge clk);
    a = x; b = y; ci = cin; sub = sb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = rand_wide(); b = rand_wide(); ci = $urandom_range(0, 1); sub = $urandom_range(0, 1);
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '1; b = '1; ci = 1'b1; sub = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, co} !== 3'b000 || s !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b co=%b s=%h required all zero", busy, done, co, s);
    end
    rst = 1'b0;
  endtask

  task automatic test_carry_ripple();
    int lat, bc;
    run_op('1, N'(1), 1'b0, 1'b0, lat, bc);
    n_checks++;
    if (lat !== 5) begin n_fail++; $display("FAIL ripple_latency: got %0d required 5", lat); end
    n_checks++;
    if (s !== '0 || co !== 1'b1) begin
      n_fail++; $display("FAIL ripple_result: s=%h co=%b required s=0 co=1", s, co);
    end
    n_checks++;
    if (bc !== 5) begin n_fail++; $display("FAIL ripple_busy_cycles: got %0d required 5", bc); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL ripple_after_done: busy=%b done=%b required 0 0", busy, done);
    end
    n_checks++;
    if (s !== '0 || co !== 1'b1) begin
      n_fail++; $display("FAIL ripple_hold: s=%h co=%b required s=0 co=1", s, co);
    end
  endtask

  task automatic test_carry_in();
    int lat, bc;
    logic [N-1:0] x;
    run_op('0, '0, 1'b1, 1'b0, lat, bc);
    n_checks++;
    if (s !== N'(1) || co !== 1'b0) begin
      n_fail++; $display("FAIL carry_in_zero: s=%h co=%b required s=1 co=0", s, co);
    end
    x = '0; x[95:0] = '1;
    run_op(x, '0, 1'b1, 1'b0, lat, bc);
    n_checks++;
    if (s !== (N'(1) << 96) || co !== 1'b0) begin
      n_fail++; $display("FAIL carry_in_96: s=%h co=%b required s=2^96 co=0", s, co);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [N-1:0] x, y;
    logic cin;
    logic [N:0] exp_v;
    for (int i = 0; i < 12; i++) begin
      x = rand_wide(); y = rand_wide(); cin = $urandom_range(0, 1);
      if (i == 0) y = ~x;
      exp_v = ref_calc(x, y, cin, 1'b0);
      run_op(x, y, cin, 1'b0, lat, bc);
      n_checks++;
      if ({co, s} !== exp_v || lat !== 5) begin
        n_fail++;
        $display("FAIL random_%0d: co=%b s=%h lat=%0d required co=%b s=%h lat=5",
                 i, co, s, lat, exp_v[N], exp_v[N-1:0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [N-1:0] x, y, s_got;
    logic co_got;
    logic [N:0] exp_v;
    int dcnt;
    x = rand_wide(); y = rand_wide();
    exp_v = ref_calc(x, y, 1'b1, 1'b0);
    dcnt = 0; s_got = '0; co_got = 1'b0;
    @(negedge clk);
    a = x; b = y; ci = 1'b1; sub = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      start = (cyc == 2 || cyc == 4);
      if (start) begin a = rand_wide(); b = rand_wide(); ci = 1'b0; end
      if (done) begin dcnt++; s_got = s; co_got = co; end
    end
    start = 1'b0;
    n_checks++;
    if (dcnt !== 1) begin n_fail++; $display("FAIL ignored_done_count: got %0d required 1", dcnt); end
    n_checks++;
    if ({co_got, s_got} !== exp_v) begin
      n_fail++;
      $display("FAIL ignored_result: co=%b s=%h required co=%b s=%h", co_got, s_got, exp_v[N], exp_v[N-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, t1, t2;
    @(negedge clk);
    a = N'(5); b = N'(7); ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = N'(1) << 127; b = N'(1) << 127;
    cyc = 1; t1 = -1; t2 = -1;
    while (t2 < 0 && cyc < 40) begin
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc;
          n_checks++;
          if (s !== N'(12) || co !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: s=%h co=%b required s=12 co=0", s, co);
          end
        end else begin
          t2 = cyc;
          start = 1'b0;
        end
      end
      if (t2 < 0) begin @(negedge clk); cyc++; end
    end
    start = 1'b0;
    n_checks++;
    if (t1 < 0 || t2 < 0) begin
      n_fail++; $display("FAIL b2b_timeout: t1=%0d t2=%0d required both seen", t1, t2);
    end else begin
      n_checks++;
      if (s !== '0 || co !== 1'b1) begin
        n_fail++; $display("FAIL b2b_second: s=%h co=%b required s=0 co=1", s, co);
      end
      n_checks++;
      if (t2 - t1 !== 6) begin n_fail++; $display("FAIL b2b_gap: got %0d required 6", t2 - t1); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dcnt;
    @(negedge clk);
    a = rand_wide() | N'(1); b = '0; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || s !== '0 || co !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b co=%b s=%h required all zero", busy, done, co, s);
    end
    dcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    n_checks++;
    if (dcnt !== 0) begin n_fail++; $display("FAIL reset_mid_done: got %0d pulses required 0", dcnt); end
  endtask

`ifdef MP_ADD_SUB_EN
  task automatic test_sub();
    int lat, bc;
    logic [N-1:0] x, y;
    logic [N:0] exp_v;
    run_op(N'(5), N'(7), 1'b0, 1'b1, lat, bc);
    n_checks++;
    if (s !== ('1 - N'(1)) || co !== 1'b0) begin
      n_fail++; $display("FAIL sub_5_7: s=%h co=%b required s=2^128-2 co=0", s, co);
    end
    run_op(N'(7), N'(5), 1'b0, 1'b1, lat, bc);
    n_checks++;
    if (s !== N'(2) || co !== 1'b1) begin
      n_fail++; $display("FAIL sub_7_5: s=%h co=%b required s=2 co=1", s, co);
    end
    for (int i = 0; i < 4; i++) begin
      x = rand_wide(); y = rand_wide();
      exp_v = ref_calc(x, y, 1'b0, 1'b1);
      run_op(x, y, 1'b0, 1'b1, lat, bc);
      n_checks++;
      if ({co, s} !== exp_v) begin
        n_fail++; $display("FAIL sub_random_%0d: co=%b s=%h required co=%b s=%h",
                           i, co, s, exp_v[N], exp_v[N-1:0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef MP_ADD_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
